// File: rtl/mmio_arbiter.sv
// mmio_arbiter: shares the MMIO peripheral bus between the CPU data port (m0)
// and the debug/DMA port (m1). One transaction in flight at a time, all
// outputs registered. Optional macro MMIO_ARB_TIMEOUT_EN adds an abort after
// TIMEOUT_CYCLES consecutive mmio_wait cycles; without it err outputs are 0.
module mmio_arbiter #(
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_byte_select,
  input  logic        m0_byte_enable,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_byte_select,
  input  logic        m1_byte_enable,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        m1_err,
  output logic        mmio_en,
  output logic        mmio_write_enable,
  output logic        mmio_byte_select,
  output logic        mmio_byte_enable,
  output logic [15:0] mmio_addr,
  output logic [15:0] mmio_data_in,
  input  logic [15:0] mmio_data_out,
  input  logic        mmio_wait
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ, DONE} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;       // 0 = m0 granted, 1 = m1 granted
  logic        last_q, last_d;     // port served most recently
  logic        we_q, we_d;
  logic        en_q, en_d;
  logic        wen_q, wen_d;
  logic        bs_q, bs_d;
  logic        be_q, be_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [15:0] m0_rdata_q, m0_rdata_d;
  logic [15:0] m1_rdata_q, m1_rdata_d;
  logic        win;

`ifdef MMIO_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_err_q, m1_err_d;
  assign m0_err = m0_err_q;
  assign m1_err = m1_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  // Winner when both request: m0 under fixed priority, else the port not served last.
  assign win = (m0_req && m1_req) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_q) : m1_req;

  // Next-state, bus field and response computation.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    en_d       = en_q;
    wen_d      = wen_q;
    bs_d       = bs_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
`ifdef MMIO_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = win;
          we_d    = win ? m1_we : m0_we;
          bs_d    = win ? m1_byte_select : m0_byte_select;
          be_d    = win ? m1_byte_enable : m0_byte_enable;
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          en_d    = 1'b1;
          wen_d   = win ? m1_we : m0_we;
          state_d = ACCESS;
`ifdef MMIO_ARB_TIMEOUT_EN
          tmo_cnt_d = 16'h0000;
`endif
        end
      end
      ACCESS: begin
        if (mmio_wait) begin
`ifdef MMIO_ARB_TIMEOUT_EN
          if (tmo_cnt_q == TMO_LAST) begin
            // Peripheral stuck: abandon the access and report it with the ack.
            en_d    = 1'b0;
            wen_d   = 1'b0;
            state_d = DONE;
            if (gnt_q) begin
              m1_ack_d   = 1'b1;
              m1_err_d   = 1'b1;
              m1_rdata_d = 16'h0000;
            end else begin
              m0_ack_d   = 1'b1;
              m0_err_d   = 1'b1;
              m0_rdata_d = 16'h0000;
            end
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'h0001;
          end
`endif
        end else begin
          en_d  = 1'b0;
          wen_d = 1'b0;
          if (we_q) begin
            state_d = DONE;
            if (gnt_q) m1_ack_d = 1'b1;
            else       m0_ack_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        // Peripheral output is registered, so it reflects the held address now.
        state_d = DONE;
        if (gnt_q) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = mmio_data_out;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = mmio_data_out;
        end
      end
      DONE: begin
        // Requests are deliberately not sampled here to avoid double service.
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      en_q       <= 1'b0;
      wen_q      <= 1'b0;
      bs_q       <= 1'b0;
      be_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 16'h0000;
      m1_rdata_q <= 16'h0000;
`ifdef MMIO_ARB_TIMEOUT_EN
      tmo_cnt_q  <= 16'h0000;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      en_q       <= en_d;
      wen_q      <= wen_d;
      bs_q       <= bs_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef MMIO_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
`endif
    end
  end

  assign m0_ack            = m0_ack_q;
  assign m1_ack            = m1_ack_q;
  assign m0_rdata          = m0_rdata_q;
  assign m1_rdata          = m1_rdata_q;
  assign mmio_en           = en_q;
  assign mmio_write_enable = wen_q;
  assign mmio_byte_select  = bs_q;
  assign mmio_byte_enable  = be_q;
  assign mmio_addr         = addr_q;
  assign mmio_data_in      = wdata_q;

endmodule
